fp_norm_round: RTL

- Downstream normalize/round/pack stage of the single-precision FP arithmetic unit.
- Consumes the raw sign, exponent and mantissa produced by the add/sub/mul/div datapath (selected by op[1:0]).
- Emits the packed IEEE-754 binary32 word that appears on the unit's result bus, plus exception flags.
- Two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/fp_norm_round.sv | 92 +++++++++
 1 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize / round-to-nearest-even / pack stage producing binary32 results
module fp_norm_round #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          FTZ  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);
  if (FTZ != 1) begin : g_ftz_check
    $error("fp_norm_round: only FTZ=1 is supported");
  end
  logic               s1_valid_q, s1_sign_q, out_valid_q;
  logic [1:0]         s1_kind_q, s1_kind_d;
  logic signed [10:0] s1_exp_q, s1_exp_d, exp_r;
  logic [26:0]        s1_mant_q, s1_mant_d;
  logic [4:0]         lz;
  logic               s2_can_load, up, carry, inexact;
  logic [24:0]        rm;
  logic [22:0]        frac;
  logic [31:0]        out_result_q, out_result_d;
  logic [2:0]         out_flags_q, out_flags_d;
  assign s2_can_load = !out_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  // normalize: fold a weight-2 carry back with sticky, or left-justify the leading one into bit 26
  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) if (in_mant[i]) lz = 5'(26 - i);
    s1_kind_d = (in_kind == 2'd0 && in_mant == '0) ? 2'd1 : in_kind;
    s1_mant_d = in_mant[27] ? {in_mant[27:2], in_mant[1] | in_mant[0]} : in_mant[26:0] << lz;
    s1_exp_d  = in_mant[27] ? {in_exp[9], in_exp} + 11'sd1 : {in_exp[9], in_exp} - {6'd0, lz};
  end
  // round to nearest even, renormalize on carry-out, then classify and pack
  always_comb begin
    up           = s1_mant_q[2] & (s1_mant_q[3] | s1_mant_q[1] | s1_mant_q[0]);
    inexact      = |s1_mant_q[2:0];
    rm           = {1'b0, s1_mant_q[26:3]} + {24'd0, up};
    carry        = rm[24];
    frac         = carry ? rm[23:1] : rm[22:0];
    exp_r        = s1_exp_q + {10'd0, carry};
    out_result_d = s1_kind_q == 2'd3 ? QNAN :
                   s1_kind_q == 2'd2 ? {s1_sign_q, 8'hFF, 23'h0} :
                   s1_kind_q == 2'd1 ? {s1_sign_q, 31'h0} :
                   exp_r >= 11'sd255 ? {s1_sign_q, 8'hFF, 23'h0} :
                   exp_r <= 11'sd0   ? {s1_sign_q, 31'h0} :
                   {s1_sign_q, exp_r[7:0], frac};
    out_flags_d  = s1_kind_q != 2'd0 ? 3'b000 :
                   exp_r >= 11'sd255 ? 3'b101 :
                   exp_r <= 11'sd0   ? 3'b011 :
                   {2'b00, inexact};
  end
  // stage 1 register: advances whenever it is empty or its item moves on
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= '0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      s1_kind_q  <= s1_kind_d;
      s1_sign_q  <= in_sign;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
    end
  // output register: holds the packed result stable while downstream stalls
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (s2_can_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= out_result_d;
        out_flags_q  <= out_flags_d;
      end
    end
endmodule
